// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path and a NIC DMA
// requester: CPU has fixed priority, with a forced one-cycle DMA grant after sustained denial.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
    logic                 rd_cpu_q, rd_cpu_d;
    logic                 rd_dma_q, rd_dma_d;
    logic                 cpu_gnt;
    logic                 dma_gnt_raw;

    // A forced window only overrides the CPU if the DMA is actually asking.
    always_comb begin
        cpu_gnt     = 1'b0;
        dma_gnt_raw = 1'b0;
        if (state_q == ST_FORCE && dma_req) begin
            dma_gnt_raw = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt_raw = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rd_cpu_d     = cpu_gnt & ~cpu_we;
        rd_dma_d     = dma_gnt_raw & ~dma_we;
        case (state_q)
            ST_FORCE: begin
                state_d      = ST_NORMAL;
                starve_cnt_d = '0;
            end
            default: begin
                if (dma_gnt_raw || !dma_req) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != LIMIT) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
                if (starve_cnt_q != LIMIT && starve_cnt_d == LIMIT) begin
                    state_d = ST_FORCE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
            rd_cpu_q     <= 1'b0;
            rd_dma_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_cpu_q     <= rd_cpu_d;
            rd_dma_q     <= rd_dma_d;
        end
    end

    // Control outputs are gated by reset so nothing reaches the memory or requesters while it is held.
    always_comb begin
        cpu_stall  = rst & cpu_req & ~cpu_gnt;
        dma_gnt    = rst & dma_gnt_raw;
        mem_en     = rst & (cpu_gnt | dma_gnt_raw);
        mem_we     = rst & ((cpu_gnt & cpu_we) | (dma_gnt_raw & dma_we));
        mem_addr   = dma_gnt_raw ? dma_addr : cpu_addr;
        mem_wdata  = dma_gnt_raw ? dma_wdata : cpu_wdata;
        cpu_rvalid = rst & rd_cpu_q;
        dma_rvalid = rst & rd_dma_q;
        cpu_rdata  = mem_rdata;
        dma_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a cycle-level reference model
// built from the arbitration rules, with a behavioural single-port memory attached.
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [63:0] cpu_wdata, dma_wdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [63:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [63:0] mem    [0:65535];
    logic [63:0] refMem [0:65535];

    int          vectors;
    int          miscompares;

    int          mdlDenied;
    bit          mdlForce;
    int          mdlPrevOwner;
    logic [63:0] mdlPrevData;
    bit          eCpuG, eDmaG, eStall;

    dmem_port_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(16), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        mem[a]    = d;
        refMem[a] = d;
    endtask

    // One clock cycle: drive at negedge, check combinational and returned-read outputs, then advance the model.
    task automatic applyStimulus(input logic r,
                                 input logic cr, input logic cwe, input logic [15:0] ca, input logic [63:0] cwd,
                                 input logic dr, input logic dwe, input logic [15:0] da, input logic [63:0] dwd);
        @(negedge clk);
        rst = r;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
        dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
        if (!r) begin
            mdlDenied = 0; mdlForce = 0; mdlPrevOwner = 0;
            eCpuG = 0; eDmaG = 0; eStall = 0;
        end else begin
            eDmaG  = (mdlForce && dr) || (!cr && dr);
            eCpuG  = cr && !eDmaG;
            eStall = cr && !eCpuG;
        end
        #2;
        checkOutput("cpu_stall", cpu_stall, eStall);
        checkOutput("dma_gnt", dma_gnt, eDmaG);
        checkOutput("mem_en", mem_en, eCpuG || eDmaG);
        checkOutput("mem_we", mem_we, (eCpuG && cwe) || (eDmaG && dwe));
        checkOutput("cpu_rvalid", cpu_rvalid, mdlPrevOwner == 1);
        checkOutput("dma_rvalid", dma_rvalid, mdlPrevOwner == 2);
        if (mdlPrevOwner == 1) checkOutput("cpu_rdata", cpu_rdata, mdlPrevData);
        if (mdlPrevOwner == 2) checkOutput("dma_rdata", dma_rdata, mdlPrevData);
        if (eCpuG) checkOutput("mem_addr_cpu", mem_addr, ca);
        if (eDmaG) checkOutput("mem_addr_dma", mem_addr, da);
        if (eCpuG && cwe) checkOutput("mem_wdata_cpu", mem_wdata, cwd);
        if (eDmaG && dwe) checkOutput("mem_wdata_dma", mem_wdata, dwd);
        @(posedge clk);
        if (r) begin
            mdlPrevOwner = 0;
            if (eCpuG && !cwe) begin mdlPrevOwner = 1; mdlPrevData = refMem[ca]; end
            if (eDmaG && !dwe) begin mdlPrevOwner = 2; mdlPrevData = refMem[da]; end
            if (eCpuG && cwe) refMem[ca] = cwd;
            if (eDmaG && dwe) refMem[da] = dwd;
            if (mdlForce) begin
                mdlForce  = 0;
                mdlDenied = 0;
            end else if (dr && !eDmaG) begin
                mdlDenied++;
                if (mdlDenied >= LIMIT) mdlForce = 1;
            end else begin
                mdlDenied = 0;
            end
        end
    endtask

    initial begin
        logic        cR, cWe, dR, dWe, r, cHold;
        logic [15:0] cA, dA;
        logic [63:0] cD, dD;
        vectors = 0; miscompares = 0;
        mdlDenied = 0; mdlForce = 0; mdlPrevOwner = 0; mdlPrevData = '0;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = {16'(i), 16'hA5C3, ~16'(i), 16'h1234};
            refMem[i] = mem[i];
        end
        preload(16'h0010, 64'hDEAD_BEEF);
        preload(16'h0001, 64'h1111_0000_0000_0001);
        preload(16'h0002, 64'h2222_0000_0000_0002);

        $display("[TB] T1 reset with random requests");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), {$urandom, $urandom},
                          1'($urandom), 1'($urandom), 16'($urandom), {$urandom, $urandom});
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("[TB] T2 CPU read");
        applyStimulus(1'b1, 1, 0, 16'h0010, 64'h0, 0, 0, 16'h0, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("[TB] T3 DMA in idle slot");
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 1, 1, 16'h0200, 64'h55);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 1, 0, 16'h0200, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("[TB] T4 starvation");
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 1, 0, 16'(i), 64'h0, 1, 1, 16'h0300, 64'hCAFE);
        applyStimulus(1'b1, 1, 0, 16'h5, 64'h0, 1, 1, 16'h0300, 64'hCAFE);
        applyStimulus(1'b1, 1, 0, 16'h5, 64'h0, 1, 1, 16'h0300, 64'hCAFE);
        applyStimulus(1'b1, 1, 0, 16'h5, 64'h0, 1, 1, 16'h0300, 64'hCAFE);
        applyStimulus(1'b1, 1, 0, 16'h5, 64'h0, 1, 1, 16'h0300, 64'hCAFE);
        applyStimulus(1'b1, 1, 1, 16'h6, 64'h77, 0, 0, 16'h0, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("[TB] T5 interleaved reads");
        applyStimulus(1'b1, 1, 0, 16'h0001, 64'h0, 0, 0, 16'h0, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 1, 0, 16'h0002, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("[TB] T6 reset during read return");
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 1, 0, 16'h0010, 64'h0);
        applyStimulus(1'b0, 1, 0, 16'h0, 64'h0, 1, 0, 16'h0010, 64'h0);
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1, 0, 16'h0010, 64'h0, 1, 0, 16'h0011, 64'h0);

        $display("[TB] randomized traffic");
        cHold = 0; dR = 0;
        cR = 0; cWe = 0; cA = '0; cD = '0; dWe = 0; dA = '0; dD = '0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) != 0);
            if (!cHold) begin
                cR  = ($urandom_range(0, 3) != 0);
                cWe = 1'($urandom);
                cA  = 16'($urandom_range(0, 31));
                cD  = {$urandom, $urandom};
            end
            if (!dR) begin
                dR  = ($urandom_range(0, 2) == 0);
                dWe = 1'($urandom);
                dA  = 16'($urandom_range(0, 31));
                dD  = {$urandom, $urandom};
            end
            applyStimulus(r, cR, cWe, cA, cD, dR, dWe, dA, dD);
            cHold = r && eStall;
            if (r && eDmaG) dR = 0;
        end
        applyStimulus(1'b1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
